// File: rtl/seq_mult.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : seq_mult
// Description : Sequential shift-add multiplier. It multiplies an N-bit
//               multiplicand by an M-bit multiplier into an (N+M)-bit product,
//               one partial product per clock (M clocks per result).
//               Valid/ready handshake on both input and output.
//               Optional macro SEQ_MULT_SIGNED_EN adds the signed_mode input,
//               which selects two's complement operands.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module seq_mult #(
    parameter int N = 16,
    parameter int M = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic           signed_mode,
`endif
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [M-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N+M-1:0] p,
    output logic           busy
);

    localparam int            c_AW   = N + M + 1;
    localparam int            c_CW   = $clog2(M + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(M - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [N-1:0]    r_a;
    // Upper N+1 bits: running partial sum; lower M bits: unconsumed multiplier bits.
    logic [c_AW-1:0] r_acc;
    logic [c_CW-1:0] r_count;

    logic            w_signed;
    logic            w_accept;
    logic            w_last;
    logic [N:0]      w_upper;
    logic [N:0]      w_a_ext;
    logic [N:0]      w_sum;
    logic [c_AW-1:0] w_acc_next;

`ifdef SEQ_MULT_SIGNED_EN
    logic r_signed;

    // Capture the operand interpretation once per operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_signed <= 1'b0;
        end else if (w_accept) begin
            r_signed <= signed_mode;
        end
    end

    assign w_signed = r_signed;
`else
    assign w_signed = 1'b0;
`endif

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_last   = (r_count == c_LAST);
    assign w_upper  = r_acc[c_AW-1:M];

    // One partial-product step. In signed mode the multiplier MSB has
    // negative weight, so the final step subtracts instead of adding.
    always_comb begin
        w_a_ext = {w_signed & r_a[N-1], r_a};
        if (!r_acc[0]) begin
            w_sum = w_upper;
        end else if (w_signed && w_last) begin
            w_sum = w_upper - w_a_ext;
        end else begin
            w_sum = w_upper + w_a_ext;
        end
        // The unsigned carry drops in as a plain bit. In signed mode the
        // shift is arithmetic, so the sign of the sum is replicated.
        w_acc_next = c_AW'({w_signed & w_sum[N], w_sum, r_acc[M-1:0]} >> 1);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after M steps,
    // DONE -> IDLE when the consumer takes the product.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_state_next = S_RUN;
            S_RUN:  if (w_last)    w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default:               w_state_next = S_IDLE;
        endcase
    end

    // Datapath: load operands on accept, then step once per RUN cycle.
    // The accumulator holds its value in DONE, which keeps p stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_acc   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_acc   <= {{(N + 1){1'b0}}, b};
            r_count <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_next;
            r_count <= r_count + c_CW'(1);
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_RUN);
    assign out_valid = (r_state == S_DONE);
    assign p         = r_acc[N+M-1:0];

endmodule
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_seq_mult
// Description : Self-checking bench for seq_mult (N=M=16). It applies
//               directed vectors, reset, backpressure and random operations.
//               The expected products come from plain integer arithmetic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_seq_mult;

    localparam int N = 16;
    localparam int M = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [M-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [N+M-1:0] p;
    logic           busy;
`ifdef SEQ_MULT_SIGNED_EN
    logic           signed_mode;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [N-1:0]   a;
        logic [M-1:0]   b;
        logic           sm;
        logic [N+M-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seq_mult #(.N(N), .M(M)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode (signed_mode),
`endif
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p),
        .busy        (busy)
    );

    // Reference product computed from the plain integer interpretation of the operands.
    function automatic logic [N+M-1:0] model(input logic [N-1:0] ma, input logic [M-1:0] mb,
                                             input logic sm);
        longint pa;
        longint pb;
        if (sm) begin
            pa = longint'($signed(ma));
            pb = longint'($signed(mb));
        end else begin
            pa = longint'(ma);
            pb = longint'(mb);
        end
        return (N + M)'(pa * pb);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full operation: accept, step latency, product, release.
    task automatic run_op(input string name, input logic [N-1:0] oa, input logic [M-1:0] ob,
                          input logic osm, input logic [N+M-1:0] exp);
        int guard;
        int lat;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({name, " in_ready before accept"}, 64'(in_ready), 64'd1);
        a         = oa;
        b         = ob;
        in_valid  = 1'b1;
        out_ready = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = osm;
`endif
        @(negedge clk);
        // Operands changed after accept, with in_valid still asserted, must be ignored.
        a = N'($urandom);
        b = M'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = ~osm;
`endif
        check({name, " busy in run"}, {62'd0, busy, in_ready}, 64'b10);
        lat = 0;
        while (!out_valid && lat < M + 20) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check({name, " latency"}, 64'(lat), 64'(M));
        check({name, " product"}, 64'(p), 64'(exp));
        check({name, " done flags"}, {62'd0, busy, in_ready}, 64'b00);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " release"}, {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N+M-1:0] exp;
        logic [N+M-1:0] p_hold;
        logic [N-1:0]   ra;
        logic [M-1:0]   rb;
        logic           rsm;
        int             guard;
        int             seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset state", {60'd0, in_ready, out_valid, busy, |p}, 64'b1000);
        rst = 1'b0;

        // Asynchronous reset during step 7 of 3*5.
        a        = 16'd3;
        b        = 16'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid-run busy", {62'd0, busy, |p}, 64'b11);
        #2 rst = 1'b1;
        #1 check("async reset", {60'd0, in_ready, out_valid, busy, |p}, 64'b1000);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (M + 4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("aborted op no out_valid", 64'(seen), 64'd0);
        run_op("fresh 3x5", 16'd3, 16'd5, 1'b0, 32'd15);

        // Directed vectors with hand-computed products.
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001});
        vecs.push_back('{16'h0000, 16'h1234, 1'b0, 32'h00000000});
        vecs.push_back('{16'h00A5, 16'h0000, 1'b0, 32'h00000000});
        vecs.push_back('{16'h0001, 16'hFFFF, 1'b0, 32'h0000FFFF});
        vecs.push_back('{16'h8000, 16'h0002, 1'b0, 32'h00010000});
        vecs.push_back('{16'h1234, 16'h0001, 1'b0, 32'h00001234});
        vecs.push_back('{16'h0100, 16'h0100, 1'b0, 32'h00010000});
`ifdef SEQ_MULT_SIGNED_EN
        vecs.push_back('{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1});
        vecs.push_back('{16'h8000, 16'h8000, 1'b1, 32'h40000000});
        vecs.push_back('{16'hFFFD, 16'h0005, 1'b0, 32'h0004FFF1});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001});
        vecs.push_back('{16'h0003, 16'hFFFE, 1'b1, 32'hFFFFFFFA});
`endif
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp);
        end

        // Backpressure: product and out_valid hold while out_ready is low.
        exp = model(16'h1234, 16'h5678, 1'b0);
        @(negedge clk);
        a        = 16'h1234;
        b        = 16'h5678;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        guard    = 0;
        while (!out_valid && guard < M + 20) begin
            @(negedge clk);
            guard++;
        end
        check("bp first valid", {63'd0, out_valid}, 64'd1);
        p_hold = p;
        check("bp product", 64'(p_hold), 64'(exp));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("bp hold %0d", k), {31'd0, out_valid, p}, {31'd0, 1'b1, exp});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp release", {62'd0, in_ready, out_valid}, 64'b10);

        // Random operations against the arithmetic model.
        for (int r = 0; r < 40; r++) begin
            ra  = N'($urandom);
            rb  = M'($urandom);
            rsm = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
            rsm = 1'($urandom);
`endif
            if (r < 4) rb = M'(1) << (M - 1 - r);
            run_op($sformatf("rand%0d", r), ra, rb, rsm, model(ra, rb, rsm));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
